regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 109 ++++++++++
 tb/tb_regfile_sb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, writeback, and destination reservation.
// The master drives selects/writeback/reservation, the slave returns data and busy state.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [NREAD*AW-1:0]   rd_sel;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_sel;
  logic [XLEN-1:0]       wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_sel;
  logic                  rsv_ok;
  logic [CW-1:0]         busy_cnt;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    input  rd_data, rd_busy, rsv_ok, busy_cnt
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel,
    output rd_data, rd_busy, rsv_ok, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and never busy. Writeback clears busy,
// an accepted reservation sets it; on a same-register collision the
// reservation wins. Reads bypass the same-cycle writeback.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int READ_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic [XLEN-1:0]       r_regs [NREGS];
  logic [NREGS-1:0]      r_busy;
  logic [CW-1:0]         r_busy_cnt;

  logic                  w_wr;
  logic                  w_rsv_ok;
  logic                  w_set;
  logic                  w_inc;
  logic                  w_dec;
  logic [NREAD*XLEN-1:0] w_rd_data;
  logic [NREAD-1:0]      w_rd_busy;

  // A writeback to register 0 is dropped entirely.
  assign w_wr = bus.wr_en && (bus.wr_sel != {AW{1'b0}});

  // Reservation is accepted for r0, for an idle register, or when the
  // register's producer is writing back in this same cycle.
  assign w_rsv_ok = bus.rsv_en &&
                    ((bus.rsv_sel == {AW{1'b0}}) ||
                     !r_busy[bus.rsv_sel] ||
                     (bus.wr_en && (bus.wr_sel == bus.rsv_sel)));
  assign w_set    = w_rsv_ok && (bus.rsv_sel != {AW{1'b0}});

  // Counter moves only on real busy transitions; a collision keeps the bit set.
  assign w_inc = w_set && !r_busy[bus.rsv_sel];
  assign w_dec = w_wr && r_busy[bus.wr_sel] &&
                 !(w_set && (bus.rsv_sel == bus.wr_sel));

  assign bus.rsv_ok   = w_rsv_ok;
  assign bus.busy_cnt = r_busy_cnt;

  // Register storage, busy bits and busy counter; the reservation set is
  // placed after the writeback clear so it wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {XLEN{1'b0}};
      end
      r_busy     <= {NREGS{1'b0}};
      r_busy_cnt <= {CW{1'b0}};
    end else begin
      if (w_wr) begin
        r_regs[bus.wr_sel] <= bus.wr_data;
        r_busy[bus.wr_sel] <= 1'b0;
      end
      if (w_set) begin
        r_busy[bus.rsv_sel] <= 1'b1;
      end
      r_busy_cnt <= r_busy_cnt + CW'(w_inc) - CW'(w_dec);
    end
  end

  // Per-port read value and busy flag, including same-cycle writeback bypass.
  always_comb begin
    w_rd_data = {(NREAD*XLEN){1'b0}};
    w_rd_busy = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin
      if (bus.rd_sel[i*AW +: AW] == {AW{1'b0}}) begin
        w_rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
        w_rd_busy[i]              = 1'b0;
      end else if (bus.wr_en && (bus.wr_sel == bus.rd_sel[i*AW +: AW])) begin
        w_rd_data[i*XLEN +: XLEN] = bus.wr_data;
        w_rd_busy[i]              = 1'b0;
      end else begin
        w_rd_data[i*XLEN +: XLEN] = r_regs[bus.rd_sel[i*AW +: AW]];
        w_rd_busy[i]              = r_busy[bus.rd_sel[i*AW +: AW]];
      end
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [NREAD*XLEN-1:0] r_rd_data;
    logic [NREAD-1:0]      r_rd_busy;

    // Capture the read result for the selects present at this edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data <= {(NREAD*XLEN){1'b0}};
        r_rd_busy <= {NREAD{1'b0}};
      end else begin
        r_rd_data <= w_rd_data;
        r_rd_busy <= w_rd_busy;
      end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.rd_busy = r_rd_busy;
  end else begin : g_rd_comb
    assign bus.rd_data = w_rd_data;
    assign bus.rd_busy = w_rd_busy;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a combinational-read instance (32b, 2 ports) and a
// registered-read instance (64b, 3 ports) driven side by side against a
// behavioural model, with expected values flowing through a scoreboard queue.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus0 ();
  regfile_sb_if #(.XLEN(64), .NREGS(32), .NREAD(3)) bus1 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .READ_REG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  regfile_sb #(.XLEN(64), .NREGS(32), .NREAD(3), .READ_REG(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic        d_wen   [2];
  logic [4:0]  d_wsel  [2];
  logic [63:0] d_wdata [2];
  logic        d_ren   [2];
  logic [4:0]  d_rsel  [2];
  logic [4:0]  d_sel   [2][3];

  assign bus0.wr_en   = d_wen[0];
  assign bus0.wr_sel  = d_wsel[0];
  assign bus0.wr_data = d_wdata[0][31:0];
  assign bus0.rsv_en  = d_ren[0];
  assign bus0.rsv_sel = d_rsel[0];
  assign bus0.rd_sel  = {d_sel[0][1], d_sel[0][0]};
  assign bus1.wr_en   = d_wen[1];
  assign bus1.wr_sel  = d_wsel[1];
  assign bus1.wr_data = d_wdata[1];
  assign bus1.rsv_en  = d_ren[1];
  assign bus1.rsv_sel = d_rsel[1];
  assign bus1.rd_sel  = {d_sel[1][2], d_sel[1][1], d_sel[1][0]};

  logic [63:0] m_regs [2][32];
  logic        m_busy [2][32];

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int m_cnt(int d);
    int c = 0;
    for (int r = 0; r < 32; r++) if (m_busy[d][r]) c++;
    return c;
  endfunction

  function automatic logic [63:0] exp_data(int d, logic [4:0] sel);
    logic [63:0] v;
    if (sel == 5'd0) v = 64'd0;
    else if (d_wen[d] && d_wsel[d] == sel) v = d_wdata[d];
    else v = m_regs[d][sel];
    if (d == 0) v[63:32] = 32'd0;
    return v;
  endfunction

  function automatic logic exp_busy(int d, logic [4:0] sel);
    return m_busy[d][sel] && !(d_wen[d] && d_wsel[d] == sel);
  endfunction

  function automatic logic exp_ok(int d);
    return d_ren[d] && (d_rsel[d] == 5'd0 || !m_busy[d][d_rsel[d]] ||
                        (d_wen[d] && d_wsel[d] == d_rsel[d]));
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[d][r] = 64'd0;
          m_busy[d][r] = 1'b0;
        end
      end else begin
        logic ok;
        ok = exp_ok(d);
        if (d_wen[d] && d_wsel[d] != 5'd0) begin
          m_regs[d][d_wsel[d]] = d_wdata[d];
          m_busy[d][d_wsel[d]] = 1'b0;
        end
        if (ok && d_rsel[d] != 5'd0) m_busy[d][d_rsel[d]] = 1'b1;
      end
    end
  endtask

  task automatic push(string tag, logic [63:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic pop_chk(logic [63:0] obs);
    sb_t s;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL sb_underflow observed=%h expected=queued entry", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] e);
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One clock: check combinational outputs at negedge, queue registered
  // expectations, advance the model at the edge, then drain the queue.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      push("rd0_data", exp_data(0, d_sel[0][p]));
      pop_chk(64'(bus0.rd_data[p*32 +: 32]));
      push("rd0_busy", 64'(exp_busy(0, d_sel[0][p])));
      pop_chk(64'(bus0.rd_busy[p]));
    end
    for (int d = 0; d < 2; d++) begin
      push("rsv_ok", 64'(exp_ok(d)));
      pop_chk(64'(d == 0 ? bus0.rsv_ok : bus1.rsv_ok));
      push("busy_cnt", 64'(m_cnt(d)));
      pop_chk(d == 0 ? 64'(bus0.busy_cnt) : 64'(bus1.busy_cnt));
    end
    for (int p = 0; p < 3; p++) begin
      push("rd1_data", rst ? 64'd0 : exp_data(1, d_sel[1][p]));
      push("rd1_busy", rst ? 64'd0 : 64'(exp_busy(1, d_sel[1][p])));
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int p = 0; p < 3; p++) begin
      pop_chk(bus1.rd_data[p*64 +: 64]);
      pop_chk(64'(bus1.rd_busy[p]));
    end
  endtask

  task automatic drv(int d, logic wen, logic [4:0] wsel, logic [63:0] wdata,
                     logic ren, logic [4:0] rsel);
    d_wen[d]   = wen;
    d_wsel[d]  = wsel;
    d_wdata[d] = wdata;
    d_ren[d]   = ren;
    d_rsel[d]  = rsel;
  endtask

  task automatic drv_all(logic wen, logic [4:0] wsel, logic [63:0] wdata,
                         logic ren, logic [4:0] rsel);
    drv(0, wen, wsel, wdata, ren, rsel);
    drv(1, wen, wsel, wdata, ren, rsel);
  endtask

  task automatic sel_all(logic [4:0] s);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 3; p++) d_sel[d][p] = s;
  endtask

  task automatic idle();
    drv_all(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    sel_all(5'd0);
    repeat (2) @(posedge clk);
    #1;
    model_edge();

    // Reset state, then release.
    step();
    rst = 1'b0;

    // Zero register: writes and reservations to r0 are discarded.
    drv_all(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0);
    sel_all(5'd0);
    #2;
    chk("z_rsv_ok", 64'(bus0.rsv_ok), 64'd1);
    step();
    chk("z_rd_data", 64'(bus0.rd_data[31:0]), 64'd0);
    chk("z_rd_busy", 64'(bus0.rd_busy[0]), 64'd0);
    chk("z_busy_cnt", 64'(bus0.busy_cnt), 64'd0);

    // Fill every register with its index, then read all back.
    for (int i = 1; i < 32; i++) begin
      drv_all(1'b1, 5'(i), 64'(i), 1'b0, 5'd0);
      sel_all(5'(i));
      step();
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      sel_all(5'(i));
      step();
      chk("fill0", 64'(bus0.rd_data[63:32]), 64'(i));
      chk("fill1", bus1.rd_data[191:128], 64'(i));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i < 32; i += 5) begin
      sel_all(5'(i));
      step();
      chk("post_rst0", 64'(bus0.rd_data[31:0]), 64'd0);
      chk("post_rst1", bus1.rd_data[63:0], 64'd0);
    end

    // Write bypass on the combinational instance, seen before the edge.
    idle();
    sel_all(5'd0);
    d_sel[0][0] = 5'd5;
    drv(0, 1'b1, 5'd5, 64'hA5A5_A5A5, 1'b0, 5'd0);
    #2;
    chk("bypass", 64'(bus0.rd_data[31:0]), 64'hA5A5_A5A5);
    step();

    // Scoreboard on r7: reserve, refused re-reserve, writeback clears.
    idle();
    drv_all(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    sel_all(5'd7);
    #2;
    chk("r7_rsv_ok", 64'(bus0.rsv_ok), 64'd1);
    step();
    chk("r7_cnt", 64'(bus0.busy_cnt), 64'd1);
    chk("r7_rd_busy", 64'(bus0.rd_busy[1]), 64'd1);
    #2;
    chk("r7_rersv_ok", 64'(bus0.rsv_ok), 64'd0);
    step();
    chk("r7_rersv_cnt", 64'(bus0.busy_cnt), 64'd1);
    drv_all(1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
    step();
    chk("r7_wb_cnt", 64'(bus0.busy_cnt), 64'd0);

    // Collision on busy r9: reservation wins, data lands, count holds.
    drv_all(1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    step();
    drv_all(1'b1, 5'd9, 64'h9999_0000_1234_5678, 1'b1, 5'd9);
    #2;
    chk("col_rsv_ok", 64'(bus0.rsv_ok), 64'd1);
    step();
    idle();
    sel_all(5'd9);
    #2;
    chk("col_cnt", 64'(bus0.busy_cnt), 64'd1);
    chk("col_data", 64'(bus0.rd_data[31:0]), 64'h1234_5678);
    chk("col_busy", 64'(bus0.rd_busy[0]), 64'd1);
    step();

    // Registered read: data appears on all three ports one edge later.
    idle();
    sel_all(5'd0);
    drv(1, 1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0);
    step();
    idle();
    sel_all(5'd3);
    #2;
    chk("rreg_before", bus1.rd_data[63:0], 64'd0);
    step();
    for (int p = 0; p < 3; p++)
      chk("rreg_after", bus1.rd_data[p*64 +: 64], 64'h0123_4567_89AB_CDEF);

    // Reset mid-operation drops pending reservations and ignores requests.
    drv_all(1'b0, 5'd0, 64'd0, 1'b1, 5'd12);
    step();
    drv_all(1'b0, 5'd0, 64'd0, 1'b1, 5'd13);
    step();
    rst = 1'b1;
    drv_all(1'b1, 5'd14, 64'hDEAD, 1'b1, 5'd15);
    step();
    rst = 1'b0;
    idle();
    sel_all(5'd12);
    #2;
    chk("mid_rst_cnt", 64'(bus0.busy_cnt), 64'd0);
    chk("mid_rst_busy", 64'(bus0.rd_busy[0]), 64'd0);
    step();

    // Random traffic, narrow selects first for collisions, then full range.
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = (n < 200) ? 7 : 31;
      for (int d = 0; d < 2; d++) begin
        drv(d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, hi)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, hi)));
        for (int p = 0; p < 3; p++) d_sel[d][p] = 5'($urandom_range(0, hi));
      end
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
